// File: rtl/gpio_defaults_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// gpio_defaults_pkg
// Shared types and constants for the GPIO default-configuration sequencer.
//   state_t         : sequencer FSM states
//   GPIO_CFG_WIDTH  : configuration bits per pad in the control-block chain
//   GPIO_MODE_*     : ready-made per-pad default words that callers concatenate
//                     to build the flat defaults bus
// Configuration word layout, LSB first:
//   [0] mgmt_en  [1] oeb  [2] inp_dis  [3] ib_mode_sel  [4] slow_sel
//   [5] ana_en   [6] ana_sel  [9:7] dm (pad drive mode)
// -----------------------------------------------------------------------------
package gpio_defaults_pkg;

  localparam int GPIO_CFG_WIDTH = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LOAD,
    ST_FINISH
  } state_t;

  // Management SoC owns the pad as an input, no pull (dm=001, oeb=1).
  localparam logic [GPIO_CFG_WIDTH-1:0] GPIO_MODE_MGMT_STD_INPUT_NOPULL = 10'h083;
  // Management SoC drives the pad, input buffer off (dm=110, inp_dis=1).
  localparam logic [GPIO_CFG_WIDTH-1:0] GPIO_MODE_MGMT_STD_OUTPUT       = 10'h305;
  // User project owns the pad, bidirectional (dm=110, mgmt_en=0).
  localparam logic [GPIO_CFG_WIDTH-1:0] GPIO_MODE_USER_STD_BIDIR        = 10'h300;
  // Analog passthrough, digital buffers off (dm=000, ana_en=1).
  localparam logic [GPIO_CFG_WIDTH-1:0] GPIO_MODE_ANALOG                = 10'h026;

endpackage

// File: rtl/gpio_defaults_sequencer_serial_tick.sv
// -----------------------------------------------------------------------------
// gpio_serial_tick
// Phase timer for the serial chain: a CLK_DIV down-counter that flags the last
// clk cycle of the current timed phase.
//   clk, resetn   : system clock, asynchronous active-low reset
//   i_run         : current state is a timed phase (counter runs)
//   i_reload      : state changes on the next edge (restart the phase)
//   o_phase_end   : high during the final cycle of a timed phase
// -----------------------------------------------------------------------------
module gpio_serial_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_run,
  input  logic i_reload,
  output logic o_phase_end
);

  localparam int               CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Held at RELOAD whenever not timing, so every phase starts with a full count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= RELOAD;
    end else if (!i_run || i_reload) begin
      r_cnt <= RELOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_phase_end = i_run && (r_cnt == '0);

endmodule

// File: rtl/gpio_defaults_sequencer.sv
// -----------------------------------------------------------------------------
// gpio_defaults_sequencer
// Shifts per-pad default configuration words into the GPIO control-block chain
// (highest stream bit first) and then strobes serial_load so every pad latches
// its default. Runs once after reset when AUTO_START=1, and on every start
// request seen while idle.
//   clk, resetn   : system clock, asynchronous active-low reset
//   defaults      : flat default words, pad p at [p*CFG_WIDTH +: CFG_WIDTH];
//                   read live, so it must be held stable while busy
//   start         : level request, only looked at in IDLE
//   serial_clock  : chain shift clock (chain captures on rising edge)
//   serial_data   : chain data, changes with the falling serial_clock edge
//   serial_load   : chain load strobe, CLK_DIV cycles
//   busy          : sequence in progress
//   done          : one-cycle completion pulse
// All outputs are registered.
// -----------------------------------------------------------------------------
module gpio_defaults_sequencer
  import gpio_defaults_pkg::*;
#(
  parameter int NUM_GPIO   = 38,
  parameter int CFG_WIDTH  = GPIO_CFG_WIDTH,
  parameter int CLK_DIV    = 4,
  parameter int AUTO_START = 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_GPIO*CFG_WIDTH-1:0] defaults,
  input  logic                          start,
  output logic                          serial_clock,
  output logic                          serial_data,
  output logic                          serial_load,
  output logic                          busy,
  output logic                          done
);

  localparam int               TOTAL    = NUM_GPIO * CFG_WIDTH;
  localparam int               BIT_W    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(TOTAL - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [BIT_W-1:0] r_bit;
  logic [BIT_W-1:0] w_bit_next;
  logic             r_auto_pending;
  logic             w_run;
  logic             w_reload;
  logic             w_phase_end;

  logic r_serial_clock, r_serial_data, r_serial_load, r_busy, r_done;
  logic w_serial_clock, w_serial_data, w_serial_load, w_busy, w_done;

  assign w_run    = (r_state == ST_SHIFT_LO) || (r_state == ST_SHIFT_HI) ||
                    (r_state == ST_LOAD);
  assign w_reload = (w_state_next != r_state);

  gpio_serial_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk         (clk),
    .resetn      (resetn),
    .i_run       (w_run),
    .i_reload    (w_reload),
    .o_phase_end (w_phase_end)
  );

  // State register. Outputs are registered from the next-state decode so they
  // change on the same edge as the state they belong to.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= ST_IDLE;
      r_bit          <= LAST_BIT;
      r_auto_pending <= (AUTO_START != 0);
      r_serial_clock <= 1'b0;
      r_serial_data  <= 1'b0;
      r_serial_load  <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_bit          <= w_bit_next;
      // The auto request only has to survive the first cycle after release.
      r_auto_pending <= 1'b0;
      r_serial_clock <= w_serial_clock;
      r_serial_data  <= w_serial_data;
      r_serial_load  <= w_serial_load;
      r_busy         <= w_busy;
      r_done         <= w_done;
    end
  end

  // Next-state and bit-index decode.
  // NOTE: every variable gets a default at the top of the block, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_bit_next   = r_bit;
    unique case (r_state)
      ST_IDLE: begin
        w_bit_next = LAST_BIT;
        if (start || r_auto_pending) w_state_next = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: begin
        if (w_phase_end) w_state_next = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        if (w_phase_end) begin
          if (r_bit == '0) begin
            w_state_next = ST_LOAD;
          end else begin
            w_state_next = ST_SHIFT_LO;
            w_bit_next   = r_bit - BIT_W'(1);
          end
        end
      end
      ST_LOAD: begin
        if (w_phase_end) w_state_next = ST_FINISH;
      end
      ST_FINISH: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Output decode for the state being entered.
  always_comb begin
    w_serial_clock = 1'b0;
    w_serial_data  = 1'b0;
    w_serial_load  = 1'b0;
    w_busy         = 1'b0;
    w_done         = 1'b0;
    unique case (w_state_next)
      ST_SHIFT_LO: begin
        w_busy        = 1'b1;
        w_serial_data = defaults[w_bit_next];
      end
      ST_SHIFT_HI: begin
        w_busy         = 1'b1;
        w_serial_clock = 1'b1;
        w_serial_data  = defaults[w_bit_next];
      end
      ST_LOAD: begin
        w_busy        = 1'b1;
        w_serial_load = 1'b1;
      end
      ST_FINISH: begin
        w_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign serial_clock = r_serial_clock;
  assign serial_data  = r_serial_data;
  assign serial_load  = r_serial_load;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_gpio_defaults_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gpio_defaults_sequencer
// Three instances: A (2x10, CLK_DIV=2, auto start), B (2x10, CLK_DIV=2, start
// driven), C (1x10, CLK_DIV=1, auto start). A monitor window samples one
// instance on falling clk edges, rebuilds the chain contents from rising
// serial_clock edges and, when serial_load falls, compares them with the
// expected word queued when the sequence was launched.
// -----------------------------------------------------------------------------
module tb_gpio_defaults_sequencer;
  import gpio_defaults_pkg::*;

  logic clk;
  logic rst_a, rst_b, rst_c;
  logic start_a, start_b, start_c;
  logic [19:0] defaults_a, defaults_b;
  logic [9:0]  defaults_c;
  logic sclk_a, sdata_a, load_a, busy_a, done_a;
  logic sclk_b, sdata_b, load_b, busy_b, done_b;
  logic sclk_c, sdata_c, load_c, busy_c, done_c;

  int vectors    = 0;
  int miscompares = 0;

  logic [19:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gpio_defaults_sequencer #(.NUM_GPIO(2), .CFG_WIDTH(10), .CLK_DIV(2), .AUTO_START(1)) dut_a (
    .clk(clk), .resetn(rst_a), .defaults(defaults_a), .start(start_a),
    .serial_clock(sclk_a), .serial_data(sdata_a), .serial_load(load_a),
    .busy(busy_a), .done(done_a));

  gpio_defaults_sequencer #(.NUM_GPIO(2), .CFG_WIDTH(10), .CLK_DIV(2), .AUTO_START(0)) dut_b (
    .clk(clk), .resetn(rst_b), .defaults(defaults_b), .start(start_b),
    .serial_clock(sclk_b), .serial_data(sdata_b), .serial_load(load_b),
    .busy(busy_b), .done(done_b));

  gpio_defaults_sequencer #(.NUM_GPIO(1), .CFG_WIDTH(10), .CLK_DIV(1), .AUTO_START(1)) dut_c (
    .clk(clk), .resetn(rst_c), .defaults(defaults_c), .start(start_c),
    .serial_clock(sclk_c), .serial_data(sdata_c), .serial_load(load_c),
    .busy(busy_c), .done(done_c));

  // Monitor view of the selected instance.
  int   mon_sel = 0;
  logic mon_sclk, mon_sdata, mon_load, mon_busy, mon_done;
  always_comb begin
    {mon_sclk, mon_sdata, mon_load, mon_busy, mon_done} = {sclk_a, sdata_a, load_a, busy_a, done_a};
    case (mon_sel)
      1: {mon_sclk, mon_sdata, mon_load, mon_busy, mon_done} = {sclk_b, sdata_b, load_b, busy_b, done_b};
      2: {mon_sclk, mon_sdata, mon_load, mon_busy, mon_done} = {sclk_c, sdata_c, load_c, busy_c, done_c};
      default: ;
    endcase
  end

  // Window statistics.
  logic [19:0] mon_shreg = '0;
  int m_edges, m_busy, m_done, m_load, m_load_bad, m_sclk_hi, m_ones;
  int m_first_busy, m_done_idx, m_gap, m_unstable;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples the selected instance for ncycles falling clk edges. When
  // pulse_idx >= 0, start_b is driven high only after sample pulse_idx.
  task automatic run_window(input int sel, input int ncycles, input int pulse_idx);
    logic p_sclk, p_sdata, p_load, p_busy;
    logic [19:0] exp_v;
    mon_sel = sel;
    #1;
    {p_sclk, p_sdata, p_load, p_busy} = {mon_sclk, mon_sdata, mon_load, mon_busy};
    m_edges = 0; m_busy = 0; m_done = 0; m_load = 0; m_load_bad = 0;
    m_sclk_hi = 0; m_ones = 0; m_unstable = 0;
    m_first_busy = -1; m_done_idx = -1; m_gap = -1;
    for (int i = 0; i < ncycles; i++) begin
      @(negedge clk);
      if (mon_busy) begin
        m_busy++;
        if (m_first_busy < 0) m_first_busy = i;
      end
      if (mon_busy && !p_busy && m_done_idx >= 0 && m_gap < 0) m_gap = i - m_done_idx;
      if (mon_done) begin
        m_done++;
        if (m_done_idx < 0) m_done_idx = i;
      end
      if (mon_load) begin
        m_load++;
        if (mon_sdata || mon_sclk) m_load_bad++;
      end
      if (mon_sclk) m_sclk_hi++;
      if (mon_sclk && !p_sclk) begin
        m_edges++;
        mon_shreg = {mon_shreg[18:0], mon_sdata};
        if (mon_sdata) m_ones++;
      end
      // Data may only move with a falling serial_clock or at sequence start.
      if ((mon_sdata != p_sdata) && !(p_sclk && !mon_sclk) && !(mon_busy && !p_busy))
        m_unstable++;
      if (p_load && !mon_load) begin
        vectors++;
        assert (exp_q.size() != 0) else begin
          miscompares++;
          $error("FAIL sb_unexpected_load: observed load strobe with chain %0h, expected no strobe", mon_shreg);
        end
        if (exp_q.size() != 0) begin
          exp_v = exp_q.pop_front();
          check($sformatf("sb_chain_dut%0d", sel), 32'(mon_shreg), 32'(exp_v));
        end
        mon_shreg = '0;
      end
      {p_sclk, p_sdata, p_load, p_busy} = {mon_sclk, mon_sdata, mon_load, mon_busy};
      if (pulse_idx >= 0) start_b = (i == pulse_idx);
    end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    defaults_a = 20'hA5C3F;
    defaults_b = {GPIO_MODE_MGMT_STD_OUTPUT, GPIO_MODE_MGMT_STD_INPUT_NOPULL};
    defaults_c = 10'h001;
    repeat (3) @(negedge clk);

    // Reset state of all three instances.
    check("reset_outputs_a", 32'({sclk_a, sdata_a, load_a, busy_a, done_a}), 32'h0);
    check("reset_outputs_b", 32'({sclk_b, sdata_b, load_b, busy_b, done_b}), 32'h0);
    check("reset_outputs_c", 32'({sclk_c, sdata_c, load_c, busy_c, done_c}), 32'h0);

    // Auto start after reset release.
    exp_q.push_back(20'hA5C3F);
    mon_shreg = '0;
    rst_a = 1'b1;
    run_window(0, 100, -1);
    check("auto_rise_edges", 32'(m_edges), 32'd20);
    check("auto_busy_cycles", 32'(m_busy), 32'd82);
    check("auto_first_busy", 32'(m_first_busy), 32'd0);
    check("auto_load_cycles", 32'(m_load), 32'd2);
    check("auto_load_quiet", 32'(m_load_bad), 32'd0);
    check("auto_done_count", 32'(m_done), 32'd1);
    check("auto_done_offset", 32'(m_done_idx - m_first_busy), 32'd82);
    check("auto_data_stable", 32'(m_unstable), 32'd0);
    check("auto_sb_drained", 32'(exp_q.size()), 32'd0);

    // No auto start when AUTO_START=0.
    rst_b = 1'b1;
    run_window(1, 5, -1);
    check("noauto_idle_busy", 32'(m_busy), 32'd0);

    // Single start pulse, second pulse mid-sequence must be ignored.
    exp_q.push_back(defaults_b);
    start_b = 1'b1;
    run_window(1, 100, 38);
    check("start_first_busy", 32'(m_first_busy), 32'd0);
    check("start_done_offset", 32'(m_done_idx), 32'd82);
    check("start_rise_edges", 32'(m_edges), 32'd20);
    check("start_done_count", 32'(m_done), 32'd1);
    check("start_busy_cycles", 32'(m_busy), 32'd82);
    check("start_sb_drained", 32'(exp_q.size()), 32'd0);

    // Reset in cycle 30 of a sequence.
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    run_window(0, 29, -1);
    check("abort_busy_before", 32'(busy_a), 32'd1);
    @(posedge clk);
    #2 rst_a = 1'b0;
    #1 check("abort_outputs_zero", 32'({sclk_a, sdata_a, load_a, busy_a, done_a}), 32'h0);
    check("abort_no_load", 32'(m_load), 32'd0);
    @(negedge clk);
    defaults_a = 20'h5F0A3;
    exp_q.push_back(20'h5F0A3);
    mon_shreg = '0;
    rst_a = 1'b1;
    run_window(0, 100, -1);
    check("rerun_rise_edges", 32'(m_edges), 32'd20);
    check("rerun_busy_cycles", 32'(m_busy), 32'd82);
    check("rerun_load_cycles", 32'(m_load), 32'd2);
    check("rerun_done_offset", 32'(m_done_idx - m_first_busy), 32'd82);
    check("rerun_sb_drained", 32'(exp_q.size()), 32'd0);

    // start held high: back-to-back sequences with one idle cycle between.
    defaults_b = {GPIO_MODE_ANALOG, GPIO_MODE_USER_STD_BIDIR};
    exp_q.push_back(defaults_b);
    exp_q.push_back(defaults_b);
    start_b = 1'b1;
    run_window(1, 200, -1);
    check("held_done_count", 32'(m_done), 32'd2);
    check("held_busy_cycles", 32'(m_busy), 32'd196);
    check("held_rise_edges", 32'(m_edges), 32'd48);
    check("held_idle_gap", 32'(m_gap), 32'd2);
    check("held_sb_drained", 32'(exp_q.size()), 32'd0);
    start_b = 1'b0;
    exp_q.push_back(defaults_b);
    run_window(1, 100, -1);
    check("drain_done_count", 32'(m_done), 32'd1);
    check("drain_rise_edges", 32'(m_edges), 32'd12);
    check("drain_sb_drained", 32'(exp_q.size()), 32'd0);

    // CLK_DIV=1, single pad, only the last bit set.
    exp_q.push_back(20'h00001);
    mon_shreg = '0;
    rst_c = 1'b1;
    run_window(2, 40, -1);
    check("div1_busy_cycles", 32'(m_busy), 32'd21);
    check("div1_rise_edges", 32'(m_edges), 32'd10);
    check("div1_sclk_high", 32'(m_sclk_hi), 32'd10);
    check("div1_ones_captured", 32'(m_ones), 32'd1);
    check("div1_load_cycles", 32'(m_load), 32'd1);
    check("div1_done_offset", 32'(m_done_idx - m_first_busy), 32'd21);
    check("div1_data_stable", 32'(m_unstable), 32'd0);
    check("div1_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
